bj_ctrl: RTL and testbench

//  Sequences branch/jump resolution in ID. Stalls on unready operands, then takes CMP_TAKEN from the branch comparator.

---
 rtl/bj_pkg.sv | 22 ++
 rtl/bj_stat_cnt.sv | 17 +
 rtl/bj_ctrl.sv | 149 ++++++++++++++
 tb/tb_bj_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared encodings for the branch/jump resolution controller: the BRANCH_JUMP
// opcode field and the controller FSM states.
package bj_pkg;

  typedef enum logic [2:0] {
    BJ_BEQ  = 3'b000,
    BJ_BNE  = 3'b001,
    BJ_NONE = 3'b010,
    BJ_JUMP = 3'b011,
    BJ_BLT  = 3'b100,
    BJ_BGE  = 3'b101,
    BJ_BLTU = 3'b110,
    BJ_BGEU = 3'b111
  } bj_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } bj_state_e;

endpackage

// File: rtl/bj_stat_cnt.sv
// 32-bit saturating event counter used by the optional branch statistics.
module bj_stat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 32'd0;
    end else if (en && count != 32'hFFFF_FFFF) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/bj_ctrl.sv
// Branch/jump resolution controller in ID: stalls on unready operands, then
// redirects the PC and squashes wrong-path fetches. Optional stats: BJ_STATS_EN.
module bj_ctrl
  import bj_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BJ_VALID,
  input  logic [2:0]  BRANCH_JUMP,
  input  logic        RS1_HAZ,
  input  logic        RS2_HAZ,
  input  logic        CMP_TAKEN,
  output logic        PC_SEL_OUT,
  output logic        STALL_OUT,
  output logic        FLUSH_IFID_OUT,
  output logic        FLUSH_IDEX_OUT,
  output logic        BUSY_OUT,
  output logic        HAZ_TIMEOUT_OUT
`ifdef BJ_STATS_EN
  ,
  output logic [31:0] BR_CNT_OUT,
  output logic [31:0] TAKEN_CNT_OUT,
  output logic [31:0] STALL_CNT_OUT
`endif
);

  localparam logic [3:0] WMAX = 4'(MAX_WAIT);
  localparam logic [2:0] FLEN = 3'(FLUSH_CYCLES);

  bj_state_e  state, state_nx;
  logic [3:0] wcnt, wcnt_nx;
  logic [2:0] fcnt, fcnt_nx;
  logic       haz_q, haz_set;
  logic       bj, is_jump, need, taken, resolve;
  logic       pc_sel, stall, flush_ifid, flush_idex;

  assign is_jump = (BRANCH_JUMP == BJ_JUMP);
  assign bj      = BJ_VALID && (BRANCH_JUMP != BJ_NONE);
  assign need    = RS1_HAZ | (RS2_HAZ & ~is_jump);
  assign taken   = is_jump | CMP_TAKEN;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      wcnt  <= 4'd0;
      fcnt  <= 3'd0;
      haz_q <= 1'b0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      fcnt  <= fcnt_nx;
      haz_q <= haz_q | haz_set;
    end
  end

  // Outputs are Mealy so a ready branch redirects in the cycle it sits in ID;
  // RESET masks them so nothing escapes while the state is being cleared.
  always_comb begin
    state_nx   = state;
    wcnt_nx    = wcnt;
    fcnt_nx    = fcnt;
    haz_set    = 1'b0;
    resolve    = 1'b0;
    pc_sel     = 1'b0;
    stall      = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (!RESET) begin
      case (state)
        IDLE: begin
          if (bj) begin
            if (need) begin
              stall      = 1'b1;
              flush_idex = 1'b1;
              state_nx   = WAIT;
              wcnt_nx    = 4'd1;
            end else begin
              resolve = 1'b1;
            end
          end
        end
        WAIT: begin
          if (!BJ_VALID) begin
            state_nx = IDLE;
          end else if (need) begin
            stall      = 1'b1;
            flush_idex = 1'b1;
            if (wcnt < WMAX) wcnt_nx = wcnt + 4'd1;
            if (wcnt == WMAX) haz_set = 1'b1;
          end else begin
            resolve  = 1'b1;
            state_nx = IDLE;
          end
        end
        FLUSH: begin
          flush_ifid = 1'b1;
          stall      = 1'b1;
          fcnt_nx    = (fcnt != 3'd0) ? fcnt - 3'd1 : 3'd0;
          if (fcnt <= 3'd1) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
      if (resolve && taken) begin
        pc_sel     = 1'b1;
        flush_ifid = 1'b1;
        if (FLEN != 3'd0) begin
          state_nx = FLUSH;
          fcnt_nx  = FLEN;
        end else begin
          state_nx = IDLE;
        end
      end
    end
  end

  assign PC_SEL_OUT      = pc_sel;
  assign STALL_OUT       = stall;
  assign FLUSH_IFID_OUT  = flush_ifid;
  assign FLUSH_IDEX_OUT  = flush_idex;
  assign BUSY_OUT        = (state != IDLE);
  assign HAZ_TIMEOUT_OUT = haz_q | haz_set;

`ifdef BJ_STATS_EN
  bj_stat_cnt u_br_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .en    (resolve),
    .count (BR_CNT_OUT)
  );

  bj_stat_cnt u_taken_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .en    (pc_sel),
    .count (TAKEN_CNT_OUT)
  );

  bj_stat_cnt u_stall_cnt (
    .clk   (CLK),
    .rst   (RESET),
    .en    (stall),
    .count (STALL_CNT_OUT)
  );
`endif

endmodule

// File: tb/tb_bj_ctrl.sv
// Self-checking bench for bj_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the resolution rules.
module tb_bj_ctrl;

  localparam int FLUSH_CYCLES = 1;
  localparam int MAX_WAIT     = 3;

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic       h1;
    logic       h2;
    logic       ct;
  } stim_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        BJ_VALID = 1'b0;
  logic [2:0]  BRANCH_JUMP = 3'b010;
  logic        RS1_HAZ = 1'b0;
  logic        RS2_HAZ = 1'b0;
  logic        CMP_TAKEN = 1'b0;
  logic        PC_SEL_OUT, STALL_OUT, FLUSH_IFID_OUT, FLUSH_IDEX_OUT, BUSY_OUT, HAZ_TIMEOUT_OUT;
`ifdef BJ_STATS_EN
  logic [31:0] BR_CNT_OUT, TAKEN_CNT_OUT, STALL_CNT_OUT;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: remaining flush cycles, pending hazard wait, sticky timeout, event tallies.
  int   m_flush_left;
  bit   m_waiting;
  int   m_wait_n;
  bit   m_timeout;
  int   m_br, m_taken, m_stall;
  logic [5:0] exp_o;

  bj_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .BJ_VALID        (BJ_VALID),
    .BRANCH_JUMP     (BRANCH_JUMP),
    .RS1_HAZ         (RS1_HAZ),
    .RS2_HAZ         (RS2_HAZ),
    .CMP_TAKEN       (CMP_TAKEN),
    .PC_SEL_OUT      (PC_SEL_OUT),
    .STALL_OUT       (STALL_OUT),
    .FLUSH_IFID_OUT  (FLUSH_IFID_OUT),
    .FLUSH_IDEX_OUT  (FLUSH_IDEX_OUT),
    .BUSY_OUT        (BUSY_OUT),
    .HAZ_TIMEOUT_OUT (HAZ_TIMEOUT_OUT)
`ifdef BJ_STATS_EN
    ,
    .BR_CNT_OUT      (BR_CNT_OUT),
    .TAKEN_CNT_OUT   (TAKEN_CNT_OUT),
    .STALL_CNT_OUT   (STALL_CNT_OUT)
`endif
  );

  always #5 CLK = ~CLK;

  // Bit order everywhere: {pc_sel, stall, flush_ifid, flush_idex, busy, haz_timeout}.
  function automatic logic [5:0] obs();
    return {PC_SEL_OUT, STALL_OUT, FLUSH_IFID_OUT, FLUSH_IDEX_OUT, BUSY_OUT, HAZ_TIMEOUT_OUT};
  endfunction

  function automatic stim_t mk(input logic v, input logic [2:0] op, input logic h1,
                               input logic h2, input logic ct);
    stim_t s;
    s.v = v; s.op = op; s.h1 = h1; s.h2 = h2; s.ct = ct;
    return s;
  endfunction

  task automatic model_clear();
    m_flush_left = 0;
    m_waiting    = 1'b0;
    m_wait_n     = 0;
    m_timeout    = 1'b0;
    m_br         = 0;
    m_taken      = 0;
    m_stall      = 0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET = 1'b1;
    BJ_VALID = 1'b0; BRANCH_JUMP = 3'b010; RS1_HAZ = 1'b0; RS2_HAZ = 1'b0; CMP_TAKEN = 1'b0;
    model_clear();
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Drives one cycle of stimulus, then predicts this cycle's outputs and advances the model.
  task automatic drive_cycle(input stim_t s);
    logic bj, need, taken, resolve, hz_now;
    logic e_pc, e_stall, e_ifid, e_idex, e_busy, e_haz;
    @(posedge CLK);
    #1;
    BJ_VALID = s.v; BRANCH_JUMP = s.op; RS1_HAZ = s.h1; RS2_HAZ = s.h2; CMP_TAKEN = s.ct;
    #3;
    bj      = s.v && (s.op != 3'b010);
    need    = s.h1 || (s.h2 && s.op != 3'b011);
    taken   = (s.op == 3'b011) || s.ct;
    resolve = 1'b0;
    hz_now  = 1'b0;
    e_pc = 1'b0; e_stall = 1'b0; e_ifid = 1'b0; e_idex = 1'b0;
    e_busy = (m_flush_left > 0) || m_waiting;
    if (m_flush_left > 0) begin
      e_ifid = 1'b1;
      e_stall = 1'b1;
      m_flush_left--;
    end else if (m_waiting) begin
      if (!s.v) begin
        m_waiting = 1'b0;
      end else if (need) begin
        e_stall = 1'b1;
        e_idex = 1'b1;
        m_wait_n++;
        if (m_wait_n >= MAX_WAIT) hz_now = 1'b1;
      end else begin
        resolve = 1'b1;
      end
    end else if (bj) begin
      if (need) begin
        e_stall = 1'b1;
        e_idex = 1'b1;
        m_waiting = 1'b1;
        m_wait_n = 0;
      end else begin
        resolve = 1'b1;
      end
    end
    if (resolve) begin
      m_br++;
      m_waiting = 1'b0;
      if (taken) begin
        e_pc = 1'b1;
        e_ifid = 1'b1;
        m_taken++;
        m_flush_left = FLUSH_CYCLES;
      end
    end
    e_haz = m_timeout || hz_now;
    m_timeout = e_haz;
    if (e_stall) m_stall++;
    exp_o = {e_pc, e_stall, e_ifid, e_idex, e_busy, e_haz};
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RESET = 1'b1;
    BJ_VALID = 1'b1; BRANCH_JUMP = 3'b011; RS1_HAZ = 1'b0; RS2_HAZ = 1'b0; CMP_TAKEN = 1'b1;
    model_clear();
    #2;
    checks++;
    if (obs() !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b want %b", obs(), 6'b000000);
    end
`ifdef BJ_STATS_EN
    checks++;
    if (BR_CNT_OUT !== 32'd0 || TAKEN_CNT_OUT !== 32'd0 || STALL_CNT_OUT !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_stats got %0d/%0d/%0d want 0/0/0", BR_CNT_OUT, TAKEN_CNT_OUT, STALL_CNT_OUT);
    end
`endif
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    BJ_VALID = 1'b0;
  endtask

  task automatic test_beq_taken();
    stim_t seq [3];
    seq[0] = mk(1, 3'b000, 0, 0, 1);
    seq[1] = mk(1, 3'b101, 0, 0, 1);
    seq[2] = mk(0, 3'b010, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(seq[i]);
      checks++;
      if (obs() !== exp_o) begin
        errors++;
        $display("[TB] FAIL beq_taken[%0d] got %b want %b", i, obs(), exp_o);
      end
    end
  endtask

  task automatic test_bne_not_taken();
    stim_t seq [2];
    seq[0] = mk(1, 3'b001, 0, 0, 0);
    seq[1] = mk(0, 3'b001, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(seq[i]);
      checks++;
      if (obs() !== exp_o) begin
        errors++;
        $display("[TB] FAIL bne_not_taken[%0d] got %b want %b", i, obs(), exp_o);
      end
    end
  endtask

  task automatic test_blt_hazard();
    stim_t seq [5];
    seq[0] = mk(1, 3'b100, 0, 1, 1);
    seq[1] = mk(1, 3'b100, 0, 1, 1);
    seq[2] = mk(1, 3'b100, 0, 0, 1);
    seq[3] = mk(0, 3'b010, 0, 0, 0);
    seq[4] = mk(0, 3'b010, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(seq[i]);
      checks++;
      if (obs() !== exp_o) begin
        errors++;
        $display("[TB] FAIL blt_hazard[%0d] got %b want %b", i, obs(), exp_o);
      end
    end
  endtask

  task automatic test_jump_rs2_ignored();
    stim_t seq [3];
    seq[0] = mk(1, 3'b011, 0, 1, 0);
    seq[1] = mk(1, 3'b000, 1, 1, 1);
    seq[2] = mk(0, 3'b010, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(seq[i]);
      checks++;
      if (obs() !== exp_o) begin
        errors++;
        $display("[TB] FAIL jump_forced[%0d] got %b want %b", i, obs(), exp_o);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    for (int i = 0; i < 9; i++) begin
      s = (i < 5) ? mk(1, 3'b110, 1, 0, 0) : ((i == 5) ? mk(1, 3'b110, 0, 0, 0) : mk(0, 3'b010, 0, 0, 0));
      drive_cycle(s);
      checks++;
      if (obs() !== exp_o) begin
        errors++;
        $display("[TB] FAIL haz_timeout[%0d] got %b want %b", i, obs(), exp_o);
      end
    end
  endtask

  task automatic test_reset_during_flush();
    drive_cycle(mk(1, 3'b011, 0, 0, 0));
    checks++;
    if (obs() !== exp_o) begin
      errors++;
      $display("[TB] FAIL rst_flush_redirect got %b want %b", obs(), exp_o);
    end
    drive_cycle(mk(1, 3'b011, 0, 0, 1));
    checks++;
    if (obs() !== exp_o) begin
      errors++;
      $display("[TB] FAIL rst_flush_inflush got %b want %b", obs(), exp_o);
    end
`ifdef BJ_STATS_EN
    checks++;
    if (BR_CNT_OUT !== 32'(m_br) || TAKEN_CNT_OUT !== 32'(m_taken) || STALL_CNT_OUT !== 32'(m_stall)) begin
      errors++;
      $display("[TB] FAIL stats_before_reset got %0d/%0d/%0d want %0d/%0d/%0d",
               BR_CNT_OUT, TAKEN_CNT_OUT, STALL_CNT_OUT, m_br, m_taken, m_stall);
    end
`endif
    RESET = 1'b1;
    #1;
    checks++;
    if (obs() !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL rst_flush_async got %b want %b", obs(), 6'b000000);
    end
`ifdef BJ_STATS_EN
    checks++;
    if (BR_CNT_OUT !== 32'd0 || TAKEN_CNT_OUT !== 32'd0) begin
      errors++;
      $display("[TB] FAIL stats_after_reset got %0d/%0d want 0/0", BR_CNT_OUT, TAKEN_CNT_OUT);
    end
`endif
    model_clear();
    @(negedge CLK);
    RESET = 1'b0;
    BJ_VALID = 1'b0;
    drive_cycle(mk(0, 3'b010, 0, 0, 0));
    checks++;
    if (obs() !== exp_o) begin
      errors++;
      $display("[TB] FAIL rst_flush_after got %b want %b", obs(), exp_o);
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic  prev_pc;
    prev_pc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      s.v  = ($urandom_range(0, 9) < 8);
      s.op = 3'($urandom_range(0, 7));
      s.h1 = ($urandom_range(0, 9) < 3);
      s.h2 = ($urandom_range(0, 9) < 3);
      s.ct = 1'($urandom_range(0, 1));
      drive_cycle(s);
      checks++;
      if (obs() !== exp_o) begin
        errors++;
        $display("[TB] FAIL random[%0d] v=%b op=%b h=%b%b ct=%b got %b want %b",
                 i, s.v, s.op, s.h1, s.h2, s.ct, obs(), exp_o);
      end
      checks++;
      if (prev_pc && PC_SEL_OUT) begin
        errors++;
        $display("[TB] FAIL pc_sel_consecutive[%0d] got 1 want 0", i);
      end
      prev_pc = PC_SEL_OUT;
    end
  endtask

  task automatic test_stats();
`ifdef BJ_STATS_EN
    #1;
    checks++;
    if (BR_CNT_OUT !== 32'(m_br)) begin
      errors++;
      $display("[TB] FAIL br_cnt got %0d want %0d", BR_CNT_OUT, m_br);
    end
    checks++;
    if (TAKEN_CNT_OUT !== 32'(m_taken)) begin
      errors++;
      $display("[TB] FAIL taken_cnt got %0d want %0d", TAKEN_CNT_OUT, m_taken);
    end
    checks++;
    if (STALL_CNT_OUT !== 32'(m_stall)) begin
      errors++;
      $display("[TB] FAIL stall_cnt got %0d want %0d", STALL_CNT_OUT, m_stall);
    end
`endif
  endtask

  initial begin
    model_clear();
    exp_o = '0;
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_blt_hazard();
    test_jump_rs2_ignored();
    test_timeout();
    test_reset_during_flush();
    apply_reset();
    test_random();
    drive_cycle(mk(0, 3'b010, 0, 0, 0));
    drive_cycle(mk(0, 3'b010, 0, 0, 0));
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
